// File: rtl/calc_key_ctrl_if.sv
// Key-event input and display-value output bundle between the keypad decoder,
// the calculator controller and the seven-segment scan stage.
interface calc_key_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [6:0] value1;
    logic [3:0] value2;
    logic [6:0] value3;
    logic [1:0] control;
    logic [1:0] op_sel;
    logic       neg;
    logic       res_valid;

    modport master (
        output key_valid, key_code,
        input  value1, value2, value3, control, op_sel, neg, res_valid
    );

    modport slave (
        input  key_valid, key_code,
        output value1, value2, value3, control, op_sel, neg, res_valid
    );
endinterface

// File: rtl/calc_key_ctrl.sv
// Single-digit keypad calculator FSM plus free-running digit-scan select generator.
// Outputs registered, key visible one cycle after acceptance; no backpressure, every key pulse is consumed.
module calc_key_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic           clk,
    input  logic           rst_n,
    calc_key_ctrl_if.slave bus
);

    localparam logic [3:0] K_ADD   = 4'hA;
    localparam logic [3:0] K_SUB   = 4'hB;
    localparam logic [3:0] K_MUL   = 4'hC;
    localparam logic [3:0] K_ENTER = 4'hE;
    localparam logic [3:0] K_CLEAR = 4'hF;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {S_A, S_OP, S_B, S_EQ, S_RES} state_t;

    state_t           state;
    logic [3:0]       a_q;
    logic [3:0]       b_q;
    logic [6:0]       res_q;
    logic [1:0]       op_q;
    logic             neg_q;
    logic             rv_q;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       ctrl_q;

    logic       is_digit;
    logic       is_op;
    logic [1:0] op_code;
    logic [6:0] result_c;
    logic       neg_c;

    always_comb begin
        is_digit = (bus.key_code <= 4'd9);
        is_op    = 1'b1;
        op_code  = 2'b00;
        case (bus.key_code)
            K_ADD:   op_code = 2'b01;
            K_SUB:   op_code = 2'b10;
            K_MUL:   op_code = 2'b11;
            default: is_op   = 1'b0;
        endcase
    end

    // Operands are single digits, so every result fits 7 bits without saturation.
    always_comb begin
        result_c = 7'd0;
        neg_c    = 1'b0;
        case (op_q)
            2'b01: result_c = {3'b000, a_q} + {3'b000, b_q};
            2'b10: begin
                neg_c    = (a_q < b_q);
                result_c = neg_c ? {3'b000, b_q - a_q} : {3'b000, a_q - b_q};
            end
            2'b11: result_c = {3'b000, a_q} * {3'b000, b_q};
            default: result_c = 7'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            res_q   <= 7'd0;
            op_q    <= 2'b00;
            neg_q   <= 1'b0;
            rv_q    <= 1'b0;
            div_cnt <= '0;
            ctrl_q  <= 2'b00;
        end else begin
            // Scan timing never depends on key traffic, including CLEAR.
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                ctrl_q  <= ctrl_q + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (bus.key_valid) begin
                if (bus.key_code == K_CLEAR) begin
                    state <= S_A;
                    a_q   <= 4'd0;
                    b_q   <= 4'd0;
                    res_q <= 7'd0;
                    op_q  <= 2'b00;
                    neg_q <= 1'b0;
                    rv_q  <= 1'b0;
                end else begin
                    case (state)
                        S_A: if (is_digit) begin
                            a_q   <= bus.key_code;
                            state <= S_OP;
                        end
                        S_OP: if (is_digit) begin
                            a_q <= bus.key_code;
                        end else if (is_op) begin
                            op_q  <= op_code;
                            state <= S_B;
                        end
                        S_B: if (is_digit) begin
                            b_q   <= bus.key_code;
                            state <= S_EQ;
                        end else if (is_op) begin
                            op_q <= op_code;
                        end
                        S_EQ: if (is_digit) begin
                            b_q <= bus.key_code;
                        end else if (bus.key_code == K_ENTER) begin
                            res_q <= result_c;
                            neg_q <= neg_c;
                            rv_q  <= 1'b1;
                            state <= S_RES;
                        end
                        // A new digit starts a fresh calculation; the result is too wide to chain.
                        S_RES: if (is_digit) begin
                            a_q   <= bus.key_code;
                            b_q   <= 4'd0;
                            res_q <= 7'd0;
                            op_q  <= 2'b00;
                            neg_q <= 1'b0;
                            rv_q  <= 1'b0;
                            state <= S_OP;
                        end
                        default: state <= S_A;
                    endcase
                end
            end
        end
    end

    assign bus.value1    = {3'b000, a_q};
    assign bus.value2    = b_q;
    assign bus.value3    = res_q;
    assign bus.control   = ctrl_q;
    assign bus.op_sel    = op_q;
    assign bus.neg       = neg_q;
    assign bus.res_valid = rv_q;

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Scoreboard bench for calc_key_ctrl with a short scan divider.
module tb_calc_key_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    calc_key_ctrl_if bus ();

    calc_key_ctrl #(.SCAN_DIV(4), .DIV_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v1;
        int v2;
        int v3;
        int op;
        int ng;
        int rv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   scan_on  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " value1"}, int'(bus.value1), 0);
        chk({tag, " value2"}, int'(bus.value2), 0);
        chk({tag, " value3"}, int'(bus.value3), 0);
        chk({tag, " op_sel"}, int'(bus.op_sel), 0);
        chk({tag, " neg"}, int'(bus.neg), 0);
        chk({tag, " res_valid"}, int'(bus.res_valid), 0);
    endtask

    // Issue one key pulse and record the outputs expected the cycle after.
    task automatic send_key(input logic [3:0] code, input int v1, input int v2,
                            input int v3, input int op, input int ng, input int rv);
        exp_t e;
        e.v1 = v1; e.v2 = v2; e.v3 = v3; e.op = op; e.ng = ng; e.rv = rv;
        @(negedge clk);
        exp_q.push_back(e);
        bus.key_code  = code;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (bus.key_valid === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("value1", int'(bus.value1), e.v1);
                    chk("value2", int'(bus.value2), e.v2);
                    chk("value3", int'(bus.value3), e.v3);
                    chk("op_sel", int'(bus.op_sel), e.op);
                    chk("neg", int'(bus.neg), e.ng);
                    chk("res_valid", int'(bus.res_valid), e.rv);
                end
            end
        end
    end

    // Posedges since the last reset release; control steps on every 4th one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (scan_on) chk("control", int'(bus.control), (cyc / 4) % 4);
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset control", int'(bus.control), 0);
        rst_n   = 1'b1;
        scan_on = 1'b1;

        // 7 + 5
        send_key(4'd7, 7, 0, 0, 0, 0, 0);
        send_key(4'hA, 7, 0, 0, 1, 0, 0);
        send_key(4'd5, 7, 5, 0, 1, 0, 0);
        send_key(4'hE, 7, 5, 12, 1, 0, 1);

        // 3 - 8 from S_RES, then a new digit clears the result
        send_key(4'd3, 3, 0, 0, 0, 0, 0);
        send_key(4'hB, 3, 0, 0, 2, 0, 0);
        send_key(4'd8, 3, 8, 0, 2, 0, 0);
        send_key(4'hE, 3, 8, 5, 2, 1, 1);
        send_key(4'd4, 4, 0, 0, 0, 0, 0);

        // ignored keys in S_OP, S_B, S_EQ
        send_key(4'hE, 4, 0, 0, 0, 0, 0);
        send_key(4'hD, 4, 0, 0, 0, 0, 0);
        send_key(4'hC, 4, 0, 0, 3, 0, 0);
        send_key(4'hE, 4, 0, 0, 3, 0, 0);
        send_key(4'hD, 4, 0, 0, 3, 0, 0);
        send_key(4'd9, 4, 9, 0, 3, 0, 0);
        send_key(4'hA, 4, 9, 0, 3, 0, 0);
        send_key(4'hD, 4, 9, 0, 3, 0, 0);
        send_key(4'hE, 4, 9, 36, 3, 0, 1);

        // ignored keys in S_RES
        send_key(4'hE, 4, 9, 36, 3, 0, 1);
        send_key(4'hA, 4, 9, 36, 3, 0, 1);
        send_key(4'hD, 4, 9, 36, 3, 0, 1);

        // 9 * 9
        send_key(4'd9, 9, 0, 0, 0, 0, 0);
        send_key(4'hC, 9, 0, 0, 3, 0, 0);
        send_key(4'd9, 9, 9, 0, 3, 0, 0);
        send_key(4'hE, 9, 9, 81, 3, 0, 1);

        // overwrites and operator replacement: 6 + 1
        send_key(4'd2, 2, 0, 0, 0, 0, 0);
        send_key(4'd6, 6, 0, 0, 0, 0, 0);
        send_key(4'hC, 6, 0, 0, 3, 0, 0);
        send_key(4'hA, 6, 0, 0, 1, 0, 0);
        send_key(4'd4, 6, 4, 0, 1, 0, 0);
        send_key(4'd1, 6, 1, 0, 1, 0, 0);
        send_key(4'hE, 6, 1, 7, 1, 0, 1);

        // CLEAR after a result, ignored keys in S_A
        send_key(4'hF, 0, 0, 0, 0, 0, 0);
        send_key(4'hE, 0, 0, 0, 0, 0, 0);
        send_key(4'hD, 0, 0, 0, 0, 0, 0);
        send_key(4'hA, 0, 0, 0, 0, 0, 0);
        send_key(4'd5, 5, 0, 0, 0, 0, 0);
        send_key(4'hF, 0, 0, 0, 0, 0, 0);

        // asynchronous reset while in S_EQ with A=6, B=2
        send_key(4'd6, 6, 0, 0, 0, 0, 0);
        send_key(4'hB, 6, 0, 0, 2, 0, 0);
        send_key(4'd2, 6, 2, 0, 2, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        chk("async_reset control", int'(bus.control), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_key(4'hE, 0, 0, 0, 0, 0, 0);

        // normal operation after reset: 3 + 4
        send_key(4'd3, 3, 0, 0, 0, 0, 0);
        send_key(4'hA, 3, 0, 0, 1, 0, 0);
        send_key(4'd4, 3, 4, 0, 1, 0, 0);
        send_key(4'hE, 3, 4, 7, 1, 0, 1);

        repeat (6) @(negedge clk);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);
        scan_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
